pad2d_stream: RTL
=================

PAD2D_STREAM -- requirements
Module: pad2d_stream

Interface
REQ-001 SHALL have parameter N, default 8, bits per channel element.
REQ-002 SHALL have parameter CHANNEL, default 3, channels carried in parallel per beat.
REQ-003 SHALL have parameter SIZE_H, default 32, input frame rows.
REQ-004 SHALL have parameter SIZE_W, default 32, input frame columns.
REQ-005 SHALL have parameters PAD_TOP, PAD_BOTTOM, PAD_LEFT, PAD_RIGHT, each default 1, border width per side; range 0..SIZE-1 is legal.
REQ-006 SHALL have parameter PAD_MODE, default 0, where 0 is zero fill and 1 is constant fill.
REQ-007 SHALL have parameter PAD_VALUE, default 0, the N-bit fill value replicated across all channels when PAD_MODE=1.
REQ-008 SHALL have ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid and in_ready are both high.
- in_data  input  CHANNEL*N  raster-order input pixel.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts the beat when out_valid and out_ready are both high.
- out_data  output  CHANNEL*N  padded raster-order pixel.
- out_last  output  1  marks the final beat of the padded frame.
- frame_done  output  1  one-cycle pulse when the last beat is accepted.

Function
REQ-009 SHALL emit an output frame of OH=SIZE_H+PAD_TOP+PAD_BOTTOM rows by OW=SIZE_W+PAD_LEFT+PAD_RIGHT columns, in raster order.
REQ-010 SHALL track the output position with a row counter and a column counter, each $clog2(OH) or $clog2(OW) bits wide and at least 1 bit.
REQ-011 SHALL treat a position as interior iff PAD_TOP<=row<PAD_TOP+SIZE_H and PAD_LEFT<=col<PAD_LEFT+SIZE_W; every other position is border.
REQ-012 SHALL implement a state machine with states IDLE and RUN.
REQ-013 SHALL, in IDLE, hold in_ready=0 and the counters at (0,0), and move to RUN on the cycle after in_valid=1 is sampled; no beat is emitted on that transition cycle.
REQ-014 SHALL define ld = !out_valid || out_ready as the output-register load enable.
REQ-015 SHALL, in RUN at an interior position, drive in_ready=ld, and on an input handshake load out_data=in_data and advance the position.
REQ-016 SHALL, in RUN at a border position, keep in_ready=0, and when ld=1 load the fill value (0, or {CHANNEL{PAD_VALUE}}) and advance the position without needing in_valid.
REQ-017 SHALL, when ld=1 and no new beat is loaded, clear out_valid; otherwise out_valid, out_data and out_last are held stable while out_valid=1 and out_ready=0.
REQ-018 SHALL advance the position as col+1, wrapping col to 0 at OW-1 and incrementing row; the beat loaded at (OH-1,OW-1) carries out_last=1.
REQ-019 SHALL return to IDLE with counters at (0,0) in the cycle the (OH-1,OW-1) beat is loaded, so back-to-back frames have one IDLE cycle between them.
REQ-020 SHALL pulse frame_done for exactly one cycle when out_valid, out_ready and out_last are all 1.
REQ-021 SHALL give a latency of one cycle from the input handshake to out_valid for interior beats, and allow a throughput of one beat per cycle with out_ready held at 1.
REQ-022 SHALL never drop or duplicate a beat under any out_ready pattern, and SHALL consume exactly SIZE_H*SIZE_W inputs per frame.
REQ-023 SHALL emit a frame with all PAD_* at 0 that equals the input frame, with out_last on beat SIZE_H*SIZE_W.

Reset
REQ-024 SHALL, while rst=1, asynchronously force state=IDLE, counters to 0, out_valid=0, out_last=0, out_data=0, frame_done=0 and in_ready=0.
REQ-025 SHALL discard a partially emitted frame on a mid-frame reset, and SHALL treat the next in_valid after release as the start of a new frame.

Verification
REQ-026 SIZE 4x4, all pads 1, PAD_MODE 0, inputs 1..16, out_ready=1 -> 36 beats: row0 is six 0s; row1 is 0,1,2,3,4,0; row5 is six 0s; out_last on beat 36; one frame_done pulse.
REQ-027 Same as REQ-026 with out_ready random at 50% and in_valid random at 50% -> identical 36-beat sequence, and out_data stable whenever a beat is stalled.
REQ-028 SIZE 3x2, PAD_TOP=0, PAD_BOTTOM=2, PAD_LEFT=1, PAD_RIGHT=0, PAD_MODE 1, PAD_VALUE 8'hFF, inputs 1..6 -> 5x3 frame with rows FF,1,2 / FF,3,4 / FF,5,6 / FF,FF,FF / FF,FF,FF.
REQ-029 Two 4x4 frames driven back-to-back, out_ready=1 -> 72 beats, two out_last beats, two frame_done pulses, and in_ready=0 for exactly one IDLE cycle between the frames.
REQ-030 Reset asserted at beat 20 of a REQ-026 frame -> all outputs 0 in the same cycle; after release a fresh frame of 1..16 produces the full correct 36-beat output.

Source files
------------

// File: rtl/pad2d_stream.sv
// pad2d_stream: adds a constant/zero border around a raster-order frame of
//   CHANNEL x N-bit pixels, producing an OH x OW raster-order output frame.
// Latency: one cycle from input handshake to out_valid for interior beats;
//   up to one beat per cycle when out_ready is held high.
// Backpressure: output is a single register stage; in_ready is high only at
//   interior positions while that register can load (empty or being drained).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     input pixel stream (valid/ready)
//   out_valid/out_ready/out_data  padded pixel stream (valid/ready)
//   out_last          final beat of the padded frame
//   frame_done        one-cycle pulse when the final beat is accepted
module pad2d_stream #(
  parameter int N          = 8,
  parameter int CHANNEL    = 3,
  parameter int SIZE_H     = 32,
  parameter int SIZE_W     = 32,
  parameter int PAD_TOP    = 1,
  parameter int PAD_BOTTOM = 1,
  parameter int PAD_LEFT   = 1,
  parameter int PAD_RIGHT  = 1,
  parameter int PAD_MODE   = 0,
  parameter int PAD_VALUE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHANNEL*N-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHANNEL*N-1:0] out_data,
  output logic                 out_last,
  output logic                 frame_done
);

  localparam int OH = SIZE_H + PAD_TOP + PAD_BOTTOM;
  localparam int OW = SIZE_W + PAD_LEFT + PAD_RIGHT;
  localparam int RW = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW = (OW > 1) ? $clog2(OW) : 1;

  // Interior window bounds, expressed inclusively so every bound fits the
  // counter width even when a bottom/right pad of zero puts the window edge
  // on the last row/column.
  localparam logic [RW-1:0] ROW_LO   = RW'(PAD_TOP);
  localparam logic [RW-1:0] ROW_HI   = RW'(PAD_TOP + SIZE_H - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);
  localparam logic [CW-1:0] COL_LO   = CW'(PAD_LEFT);
  localparam logic [CW-1:0] COL_HI   = CW'(PAD_LEFT + SIZE_W - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);

  localparam logic [N-1:0]         PAD_ELEM = N'(PAD_VALUE);
  localparam logic [CHANNEL*N-1:0] FILL     = (PAD_MODE == 1) ? {CHANNEL{PAD_ELEM}} : '0;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_nxt;
  logic [RW-1:0]          row, row_nxt;
  logic [CW-1:0]          col, col_nxt;
  logic                   ld;
  logic                   load;
  logic [CHANNEL*N-1:0]   load_dat;
  logic                   interior;
  logic                   at_last;

  assign ld       = !out_valid || out_ready;
  assign interior = (row >= ROW_LO) && (row <= ROW_HI) &&
                    (col >= COL_LO) && (col <= COL_HI);
  assign at_last  = (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    in_ready  = 1'b0;
    load      = 1'b0;
    load_dat  = FILL;
    case (state)
      IDLE: begin
        // The start cycle only arms the machine; the first beat (border or
        // interior) is produced from RUN on the following cycle.
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (interior) begin
          in_ready = ld;
          load     = ld && in_valid;
          load_dat = in_data;
        end else begin
          // Border beats are generated locally and need no input.
          load = ld;
        end
        if (load) begin
          if (at_last) begin
            state_nxt = IDLE;
            row_nxt   = '0;
            col_nxt   = '0;
          end else if (col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = row + 1'b1;
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_dat;
        out_last  <= at_last;
      end else if (ld) begin
        // Register drained (or empty) with nothing new to hold.
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Derived from registered out_valid, so it is already low during reset.
  assign frame_done = out_valid && out_ready && out_last;

endmodule
